wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 24 ++
 rtl/wb_slot.sv | 50 +++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and source encoding for the writeback arbiter and its holding slots.
package wb_arbiter_pkg;

    localparam int WB_WIDTH = 32;
    localparam int WB_NUM   = 64;
    localparam int NSRC     = 3;
    localparam int DEST_W   = 6;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_FPU = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    // Round-robin successor: alu -> fpu -> mem -> alu.
    function automatic src_e next_src(input src_e s);
        case (s)
            SRC_ALU: next_src = SRC_FPU;
            SRC_FPU: next_src = SRC_MEM;
            default: next_src = SRC_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a single result source; ready depends only on held state.
import wb_arbiter_pkg::*;

module wb_slot #(
    parameter int WIDTH = WB_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid,
    input  logic [DEST_W-1:0] dest,
    input  logic [WIDTH-1:0]  data,
    input  logic              grant,
    output logic              ready,
    output logic              full,
    output logic [DEST_W-1:0] slot_dest,
    output logic [WIDTH-1:0]  slot_data
);

    logic              full_p0;
    logic [DEST_W-1:0] dest_p0;
    logic [WIDTH-1:0]  data_p0;
    logic              load;

    assign ready = !full_p0 || grant;
    // Writes to r0 complete the handshake but never occupy the slot.
    assign load  = valid && ready && (dest != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full_p0 <= 1'b0;
        end else if (load) begin
            full_p0 <= 1'b1;
        end else if (grant) begin
            full_p0 <= 1'b0;
        end
    end

    // Payload is only observed while full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            dest_p0 <= dest;
            data_p0 <= data;
        end
    end

    assign full      = full_p0;
    assign slot_dest = dest_p0;
    assign slot_data = data_p0;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three result sources share one register-file write port.
import wb_arbiter_pkg::*;

module wb_arbiter #(
    parameter int WIDTH = WB_WIDTH,
    parameter int NUM   = WB_NUM
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 alu_valid,
    input  logic                 fpu_valid,
    input  logic                 mem_valid,
    output logic                 alu_ready,
    output logic                 fpu_ready,
    output logic                 mem_ready,
    input  logic [DEST_W-1:0]    alu_dest,
    input  logic [DEST_W-1:0]    fpu_dest,
    input  logic [DEST_W-1:0]    mem_dest,
    input  logic [WIDTH-1:0]     alu_data,
    input  logic [WIDTH-1:0]     fpu_data,
    input  logic [WIDTH-1:0]     mem_data,
    output logic [WIDTH*NUM-1:0] inreg,
    output logic [NUM-1:0]       enable,
    output logic [NUM-1:0]       pending
);

    logic              vld  [NSRC];
    logic [DEST_W-1:0] dsti [NSRC];
    logic [WIDTH-1:0]  dati [NSRC];
    logic              rdy  [NSRC];
    logic              full [NSRC];
    logic [DEST_W-1:0] sdest[NSRC];
    logic [WIDTH-1:0]  sdata[NSRC];
    logic [NSRC-1:0]   gnt_vec;

    src_e              last_grant;
    src_e              gnt_idx;
    src_e              cand;
    logic              gnt_vld;

    assign vld[SRC_ALU]  = alu_valid;
    assign vld[SRC_FPU]  = fpu_valid;
    assign vld[SRC_MEM]  = mem_valid;
    assign dsti[SRC_ALU] = alu_dest;
    assign dsti[SRC_FPU] = fpu_dest;
    assign dsti[SRC_MEM] = mem_dest;
    assign dati[SRC_ALU] = alu_data;
    assign dati[SRC_FPU] = fpu_data;
    assign dati[SRC_MEM] = mem_data;
    assign alu_ready     = rdy[SRC_ALU];
    assign fpu_ready     = rdy[SRC_FPU];
    assign mem_ready     = rdy[SRC_MEM];

    for (genvar s = 0; s < NSRC; s++) begin : g_slot
        wb_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .valid     (vld[s]),
            .dest      (dsti[s]),
            .data      (dati[s]),
            .grant     (gnt_vec[s]),
            .ready     (rdy[s]),
            .full      (full[s]),
            .slot_dest (sdest[s]),
            .slot_data (sdata[s])
        );
    end

    // Search begins one past the last winner, so any full slot waits at most two grants.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_grant;
        cand    = last_grant;
        gnt_vec = '0;
        for (int i = 0; i < NSRC; i++) begin
            cand = next_src(cand);
            if (!gnt_vld && full[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= SRC_MEM;
        end else if (gnt_vld) begin
            last_grant <= gnt_idx;
        end
    end

    always_comb begin
        enable  = '0;
        inreg   = '0;
        pending = '0;
        if (gnt_vld) begin
            enable = {{(NUM-1){1'b0}}, 1'b1} << sdest[gnt_idx];
            inreg  = {NUM{sdata[gnt_idx]}};
        end
        // r0 is hard zero; slots never hold it, but keep the port guarantee local.
        enable[0] = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (full[s]) begin
                pending = pending | ({{(NUM-1){1'b0}}, 1'b1} << sdest[s]);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single write, r0 discard, contention, fairness, reset abort.
module tb_wb_arbiter;

    localparam int W = 32;
    localparam int N = 64;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           alu_valid = 1'b0, fpu_valid = 1'b0, mem_valid = 1'b0;
    logic           alu_ready, fpu_ready, mem_ready;
    logic [5:0]     alu_dest = '0, fpu_dest = '0, mem_dest = '0;
    logic [W-1:0]   alu_data = '0, fpu_data = '0, mem_data = '0;
    logic [W*N-1:0] inreg;
    logic [N-1:0]   enable;
    logic [N-1:0]   pending;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.WIDTH(W), .NUM(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .alu_valid (alu_valid),
        .fpu_valid (fpu_valid),
        .mem_valid (mem_valid),
        .alu_ready (alu_ready),
        .fpu_ready (fpu_ready),
        .mem_ready (mem_ready),
        .alu_dest  (alu_dest),
        .fpu_dest  (fpu_dest),
        .mem_dest  (mem_dest),
        .alu_data  (alu_data),
        .fpu_data  (fpu_data),
        .mem_data  (mem_data),
        .inreg     (inreg),
        .enable    (enable),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        fpu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #2;
        checks++;
        if (enable !== '0) begin
            failures++;
            $display("FAIL reset_enable got=%h exp=0", enable);
        end
        checks++;
        if (pending !== '0) begin
            failures++;
            $display("FAIL reset_pending got=%h exp=0", pending);
        end
        checks++;
        if (inreg !== '0) begin
            failures++;
            $display("FAIL reset_inreg got_slice0=%h exp=0", inreg[W-1:0]);
        end
        checks++;
        if ({alu_ready, fpu_ready, mem_ready} !== 3'b111) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=111", {alu_ready, fpu_ready, mem_ready});
        end
        apply_reset();
        step();
    endtask

    task automatic test_single();
        apply_reset();
        step();
        alu_valid = 1'b1; alu_dest = 6'd5; alu_data = 32'h1234;
        checks++;
        if (alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready got=%b exp=1", alu_ready);
        end
        step();
        idle_inputs();
        checks++;
        if (enable !== (64'd1 << 5)) begin
            failures++;
            $display("FAIL single_enable got=%h exp=%h", enable, 64'd1 << 5);
        end
        checks++;
        if (inreg !== {N{32'h1234}}) begin
            failures++;
            $display("FAIL single_inreg got_s0=%h got_s63=%h exp=00001234", inreg[W-1:0], inreg[W*N-1 -: W]);
        end
        checks++;
        if (pending !== (64'd1 << 5)) begin
            failures++;
            $display("FAIL single_pending got=%h exp=%h", pending, 64'd1 << 5);
        end
        step();
        checks++;
        if (enable !== '0 || pending !== '0) begin
            failures++;
            $display("FAIL single_after got_en=%h got_pend=%h exp=0", enable, pending);
        end
    endtask

    task automatic test_r0_discard();
        apply_reset();
        step();
        fpu_valid = 1'b1; fpu_dest = 6'd0; fpu_data = 32'hFFFF_FFFF;
        checks++;
        if (fpu_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_ready got=%b exp=1", fpu_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            idle_inputs();
            checks++;
            if (enable !== '0 || pending !== '0 || inreg !== '0) begin
                failures++;
                $display("FAIL r0_quiet cyc=%0d got_en=%h got_pend=%h exp=0", c, enable, pending);
            end
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_en[3];
        logic [W-1:0] exp_d[3];
        logic [2:0]   exp_mr;
        exp_en[0] = 64'd1 << 3;  exp_d[0] = 32'hA1;
        exp_en[1] = 64'd1 << 40; exp_d[1] = 32'hF2;
        exp_en[2] = 64'd1 << 7;  exp_d[2] = 32'hE3;
        exp_mr = 3'b100;
        apply_reset();
        step();
        alu_valid = 1'b1; alu_dest = 6'd3;  alu_data = 32'hA1;
        fpu_valid = 1'b1; fpu_dest = 6'd40; fpu_data = 32'hF2;
        mem_valid = 1'b1; mem_dest = 6'd7;  mem_data = 32'hE3;
        step();
        idle_inputs();
        checks++;
        if (pending !== ((64'd1 << 3) | (64'd1 << 40) | (64'd1 << 7))) begin
            failures++;
            $display("FAIL cont_pending got=%h", pending);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (enable !== exp_en[c] || inreg[W-1:0] !== exp_d[c]) begin
                failures++;
                $display("FAIL cont_grant cyc=%0d got_en=%h got_d=%h exp_en=%h exp_d=%h",
                         c, enable, inreg[W-1:0], exp_en[c], exp_d[c]);
            end
            checks++;
            if (mem_ready !== exp_mr[c]) begin
                failures++;
                $display("FAIL cont_mem_ready cyc=%0d got=%b exp=%b", c, mem_ready, exp_mr[c]);
            end
            step();
        end
        checks++;
        if (enable !== '0 || pending !== '0) begin
            failures++;
            $display("FAIL cont_drain got_en=%h got_pend=%h exp=0", enable, pending);
        end
    endtask

    task automatic test_fairness();
        logic [5:0]   exp_dest[9];
        logic [W-1:0] exp_data[9];
        exp_dest = '{6'd1, 6'd20, 6'd30, 6'd2, 6'd20, 6'd30, 6'd5, 6'd20, 6'd30};
        exp_data = '{32'h10, 32'h200, 32'h300, 32'h20, 32'h200, 32'h300, 32'h50, 32'h200, 32'h300};
        apply_reset();
        step();
        fpu_valid = 1'b1; fpu_dest = 6'd20; fpu_data = 32'h200;
        mem_valid = 1'b1; mem_dest = 6'd30; mem_data = 32'h300;
        alu_valid = 1'b1; alu_dest = 6'd1;  alu_data = 32'h10;
        for (int c = 1; c <= 9; c++) begin
            step();
            alu_dest = 6'(c + 1);
            alu_data = 32'((c + 1) * 16);
            checks++;
            if (enable !== (64'd1 << exp_dest[c-1]) || inreg[W-1:0] !== exp_data[c-1]) begin
                failures++;
                $display("FAIL fair_grant cyc=%0d got_en=%h got_d=%h exp_dest=%0d exp_d=%h",
                         c, enable, inreg[W-1:0], exp_dest[c-1], exp_data[c-1]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_same_dest();
        apply_reset();
        step();
        alu_valid = 1'b1; alu_dest = 6'd9; alu_data = 32'hB;
        mem_valid = 1'b1; mem_dest = 6'd9; mem_data = 32'hA;
        step();
        idle_inputs();
        checks++;
        if (enable !== (64'd1 << 9) || inreg[W-1:0] !== 32'hB || pending !== (64'd1 << 9)) begin
            failures++;
            $display("FAIL same_first got_en=%h got_d=%h got_pend=%h exp_d=b", enable, inreg[W-1:0], pending);
        end
        step();
        checks++;
        if (enable !== (64'd1 << 9) || inreg[W-1:0] !== 32'hA || pending !== (64'd1 << 9)) begin
            failures++;
            $display("FAIL same_second got_en=%h got_d=%h got_pend=%h exp_d=a", enable, inreg[W-1:0], pending);
        end
        step();
        checks++;
        if (enable !== '0) begin
            failures++;
            $display("FAIL same_done got_en=%h exp=0", enable);
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        step();
        alu_valid = 1'b1; alu_dest = 6'd11; alu_data = 32'h11;
        fpu_valid = 1'b1; fpu_dest = 6'd12; fpu_data = 32'h22;
        mem_valid = 1'b1; mem_dest = 6'd13; mem_data = 32'h33;
        step();
        idle_inputs();
        checks++;
        if (pending !== ((64'd1 << 11) | (64'd1 << 12) | (64'd1 << 13))) begin
            failures++;
            $display("FAIL abort_loaded got_pend=%h", pending);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (enable !== '0 || pending !== '0 || inreg !== '0) begin
            failures++;
            $display("FAIL abort_immediate got_en=%h got_pend=%h exp=0", enable, pending);
        end
        checks++;
        if ({alu_ready, fpu_ready, mem_ready} !== 3'b111) begin
            failures++;
            $display("FAIL abort_ready got=%b exp=111", {alu_ready, fpu_ready, mem_ready});
        end
        step();
        #3;
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (enable !== '0 || pending !== '0) begin
                failures++;
                $display("FAIL abort_release cyc=%0d got_en=%h got_pend=%h exp=0", c, enable, pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_r0_discard();
        test_contention();
        test_fairness();
        test_same_dest();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
